// File: rtl/mips_cpu_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_cpu_muldiv_pkg
//  Brief    : Shared types and arithmetic helpers for the iterative MDU.
//  Revision : 1.0
// ============================================================================
package mips_cpu_muldiv_pkg;

    // Widest intermediate handled by the helpers (a full 2*WIDTH product, WIDTH <= 64)
    localparam int MDU_XMAX = 128;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_NOP6  = 3'd6,
        MDU_NOP7  = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_t;

    // Two's-complement negation; callers zero-extend into and truncate out of MDU_XMAX bits
    function automatic logic [MDU_XMAX-1:0] neg_w(input logic [MDU_XMAX-1:0] v);
        return (~v) + {{(MDU_XMAX-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude helper: negates v when its (caller-supplied) sign flag is set
    function automatic logic [MDU_XMAX-1:0] abs_w(input logic [MDU_XMAX-1:0] v, input logic neg);
        return neg ? neg_w(v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module   : mips_cpu_muldiv_step
//  Brief    : One combinational MDU iteration retiring BITS_PER_CYCLE bits:
//             unsigned shift-add multiply or restoring divide.
//  Revision : 1.0
// ============================================================================
module mips_cpu_muldiv_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             is_div_i,   // 1: divide step, 0: multiply step
    input  logic [WIDTH-1:0] acc_i,      // product high half / partial remainder
    input  logic [WIDTH-1:0] mq_i,       // multiplier / dividend, shifting out
    input  logic [WIDTH-1:0] opnd_i,     // multiplicand / divisor magnitude
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mq_o
);

    // Unrolled chain of single-bit steps; mq collects product low bits or quotient bits
    always_comb begin
        logic [WIDTH:0]   sum;
        logic [WIDTH+1:0] diff;
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] mq;
        acc  = acc_i;
        mq   = mq_i;
        sum  = '0;
        diff = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_div_i) begin
                // Remainder stays below the divisor (or below 2^WIDTH for a zero
                // divisor), so a non-negative trial always fits in WIDTH bits.
                diff = {1'b0, acc, mq[WIDTH-1]} - {2'b00, opnd_i};
                if (!diff[WIDTH+1]) begin
                    acc = diff[WIDTH-1:0];
                end else begin
                    acc = {acc[WIDTH-2:0], mq[WIDTH-1]};
                end
                mq = {mq[WIDTH-2:0], ~diff[WIDTH+1]};
            end else begin
                sum = {1'b0, acc} + (mq[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
                acc = sum[WIDTH:1];
                mq  = {sum[0], mq[WIDTH-1:1]};
            end
        end
        acc_o = acc;
        mq_o  = mq;
    end

endmodule
`default_nettype wire

// File: rtl/mips_cpu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : mips_cpu_muldiv
//  Brief    : Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO,
//             plus MTHI/MTLO writes. Magnitude datapath with final sign fix.
//  Revision : 1.0
// ============================================================================
module mips_cpu_muldiv
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER + 1);
    localparam int W2   = 2 * WIDTH;

    localparam logic [CW-1:0] C_ITER = CW'(ITER);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_FIX  = ST_FIX;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;   // product sign, or quotient sign
    logic             neg_hi_q, neg_hi_d;   // remainder sign (dividend sign)
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    mdu_op_t          w_op;
    logic             w_op_div;
    logic             w_op_signed;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_step_acc;
    logic [WIDTH-1:0] w_step_mq;
    logic [W2-1:0]    w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_op        = mdu_op_t'(op);
    assign w_op_div    = (w_op == MDU_DIV)  || (w_op == MDU_DIVU);
    assign w_op_signed = (w_op == MDU_MULT) || (w_op == MDU_DIV);
    assign w_sa        = w_op_signed & a[WIDTH-1];
    assign w_sb        = w_op_signed & b[WIDTH-1];

    // Unsigned WIDTH-bit magnitudes; the most-negative value maps exactly to 2^(WIDTH-1)
    assign w_mag_a = WIDTH'(abs_w(MDU_XMAX'(a), w_sa));
    assign w_mag_b = WIDTH'(abs_w(MDU_XMAX'(b), w_sb));

    // Sign-corrected results applied in FIX
    assign w_prod_fix = W2'(abs_w(MDU_XMAX'({acc_q, mq_q}), neg_lo_q));
    assign w_quo_fix  = WIDTH'(abs_w(MDU_XMAX'(mq_q), neg_lo_q));
    assign w_rem_fix  = WIDTH'(abs_w(MDU_XMAX'(acc_q), neg_hi_q));

    mips_cpu_muldiv_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .mq_i     (mq_q),
        .opnd_i   (opnd_q),
        .acc_o    (w_step_acc),
        .mq_o     (w_step_mq)
    );

    // Next-state: accept requests in IDLE, iterate in RUN, sign-fix and write HI/LO in FIX
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (w_op)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            state_d  = S_RUN;
                            cnt_d    = C_ITER;
                            acc_d    = '0;
                            is_div_d = w_op_div;
                            if (w_op_div) begin
                                mq_d     = w_mag_a;
                                opnd_d   = w_mag_b;
                                // Divide-by-zero keeps the all-ones quotient unnegated
                                neg_lo_d = (w_sa ^ w_sb) && (b != '0);
                                neg_hi_d = w_sa;
                            end else begin
                                mq_d     = w_mag_b;
                                opnd_d   = w_mag_a;
                                neg_lo_d = w_sa ^ w_sb;
                                neg_hi_d = 1'b0;
                            end
                        end
                        MDU_MTHI: hi_d = a;
                        MDU_MTLO: lo_d = a;
                        default:  ;
                    endcase
                end
            end
            S_RUN: begin
                acc_d = w_step_acc;
                mq_d  = w_step_mq;
                cnt_d = cnt_q - C_ONE;
                if (cnt_q == C_ONE) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = w_rem_fix;
                    lo_d = w_quo_fix;
                end else begin
                    {hi_d, lo_d} = w_prod_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any op in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire
